// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e        : operation encoding as presented on the op port
//   state_e     : sequencer states IDLE -> RUN -> FIXUP -> DONE
//   MDU_WIDTH   : default operand width
//   MDU_LATENCY : cycles from the start edge to the hilo_write cycle
package mdu_pkg;

   localparam int MDU_WIDTH   = 32;
   localparam int MDU_LATENCY = MDU_WIDTH + 2;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      FIXUP = 2'b10,
      DONE  = 2'b11
   } state_e;

   function automatic logic op_is_signed(input op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Combinational arithmetic for the multiply/divide unit.
// Computes one shift-add (multiply) or restoring-subtract (divide) iteration
// and the final sign/divide-by-zero correction. Holds no state.
//   op               : operation being executed
//   sign_a, sign_b   : operand signs recorded at start (0 for unsigned ops)
//   div_zero         : divisor was zero at start
//   orig_a           : dividend exactly as supplied (divide-by-zero HI)
//   acc_hi, acc_lo   : 2*WIDTH accumulator (product, or remainder/quotient)
//   shreg            : multiplier (shifts right) or dividend (shifts left)
//   oper             : multiplicand or divisor magnitude
//   step_*           : register values after one iteration
//   fix_hi, fix_lo   : final HI/LO after sign correction
module mdu_datapath
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  op_e              op,
   input  logic             sign_a,
   input  logic             sign_b,
   input  logic             div_zero,
   input  logic [WIDTH-1:0] orig_a,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] shreg,
   input  logic [WIDTH-1:0] oper,
   output logic [WIDTH-1:0] step_hi,
   output logic [WIDTH-1:0] step_lo,
   output logic [WIDTH-1:0] step_sh,
   output logic [WIDTH-1:0] fix_hi,
   output logic [WIDTH-1:0] fix_lo
);

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   diff;
   logic [2*WIDTH-1:0] prod;
   logic               negate;

   // One iteration step.
   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      sum     = '0;
      rem_sh  = '0;
      diff    = '0;
      step_hi = acc_hi;
      step_lo = acc_lo;
      step_sh = shreg;
      if (!op_is_div(op)) begin
         // The add can carry out of the upper half; the carry becomes the
         // new MSB once the 2*WIDTH product shifts right.
         sum     = {1'b0, acc_hi} + (shreg[0] ? {1'b0, oper} : '0);
         step_hi = sum[WIDTH:1];
         step_lo = {sum[0], acc_lo[WIDTH-1:1]};
         step_sh = shreg >> 1;
      end else begin
         // Shifted remainder needs WIDTH+1 bits; the difference always fits
         // in WIDTH bits because the old remainder was below the divisor.
         rem_sh  = {acc_hi, shreg[WIDTH-1]};
         diff    = rem_sh[WIDTH-1:0] - oper;
         step_sh = shreg << 1;
         if (rem_sh >= {1'b0, oper}) begin
            step_hi = diff;
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = rem_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Final correction from magnitudes back to signed results.
   always_comb begin
      negate = sign_a ^ sign_b;
      prod   = {acc_hi, acc_lo};
      fix_hi = acc_hi;
      fix_lo = acc_lo;
      if (!op_is_div(op)) begin
         if (negate) prod = -prod;
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end else if (div_zero) begin
         fix_hi = orig_a;
         fix_lo = '1;
      end else begin
         // Remainder follows the dividend's sign, quotient the XOR of signs.
         fix_lo = negate ? -acc_lo : acc_lo;
         fix_hi = sign_a ? -acc_hi : acc_hi;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide engine; writer side of the HI/LO register.
// One iteration per cycle for WIDTH cycles, one FIXUP cycle, then a DONE
// cycle presenting the result with a one-cycle hilo_write strobe.
//   clk, reset  : clock; synchronous active-high reset
//   start       : request pulse, accepted only in IDLE
//   op          : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a   : rs (multiplicand / dividend), captured at start
//   operand_b   : rt (multiplier / divisor), captured at start
//   busy        : high whenever the unit is not IDLE
//   hilo_write  : one-cycle HI/LO write strobe
//   hi_out      : HI result, held after the strobe
//   lo_out      : LO result, held after the strobe
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             hilo_write,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           state, state_next;
   op_e              op_r;
   logic             sign_a, sign_b, div_zero;
   logic [WIDTH-1:0] orig_a;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [WIDTH-1:0] shreg, oper;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] step_hi, step_lo, step_sh;
   logic [WIDTH-1:0] fix_hi, fix_lo;

   op_e              op_in;
   logic             sa, sb;
   logic [WIDTH-1:0] mag_a, mag_b;

   // Magnitudes and signs of the incoming operands; unsigned ops pass through.
   always_comb begin
      op_in = op_e'(op);
      sa    = op_is_signed(op_in) && operand_a[WIDTH-1];
      sb    = op_is_signed(op_in) && operand_b[WIDTH-1];
      mag_a = sa ? -operand_a : operand_a;
      mag_b = sb ? -operand_b : operand_b;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cnt == '0) state_next = FIXUP;
         FIXUP:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign hilo_write = (state == DONE);

   // Operand capture, iteration registers and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r     <= OP_MULT;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         orig_a   <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         shreg    <= '0;
         oper     <= '0;
         cnt      <= '0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r     <= op_in;
                  sign_a   <= sa;
                  sign_b   <= sb;
                  div_zero <= op_is_div(op_in) && (operand_b == '0);
                  orig_a   <= operand_a;
                  acc_hi   <= '0;
                  acc_lo   <= '0;
                  cnt      <= CNT_W'(WIDTH - 1);
                  // Multiply shifts the multiplier out from the LSB; divide
                  // shifts the dividend out from the MSB into the remainder.
                  if (op_is_div(op_in)) begin
                     shreg <= mag_a;
                     oper  <= mag_b;
                  end else begin
                     shreg <= mag_b;
                     oper  <= mag_a;
                  end
               end
            end
            RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               shreg  <= step_sh;
               cnt    <= cnt - CNT_W'(1);
            end
            FIXUP: begin
               hi_out <= fix_hi;
               lo_out <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
      .op       (op_r),
      .sign_a   (sign_a),
      .sign_b   (sign_b),
      .div_zero (div_zero),
      .orig_a   (orig_a),
      .acc_hi   (acc_hi),
      .acc_lo   (acc_lo),
      .shreg    (shreg),
      .oper     (oper),
      .step_hi  (step_hi),
      .step_lo  (step_lo),
      .step_sh  (step_sh),
      .fix_hi   (fix_hi),
      .fix_lo   (fix_lo)
   );

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a transaction-level model predicts
// busy/hilo_write/hi_out/lo_out every cycle; directed vectors pin the model
// with hand-computed literals.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, hilo_write;
   logic [W-1:0] hi_out, lo_out;

   int n_cmp = 0;
   int n_fail = 0;
   int n_writes = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .operand_a  (a),
      .operand_b  (b),
      .busy       (busy),
      .hilo_write (hilo_write),
      .hi_out     (hi_out),
      .lo_out     (lo_out)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: {hi, lo} for one operation.
   function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sp;
      int     q, r;
      case (o)
         2'b00: begin
            sp = longint'($signed(x)) * longint'($signed(y));
            return sp;
         end
         2'b01: return {32'b0, x} * {32'b0, y};
         2'b10: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {r, q};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // Timeline model: accept in idle, result visible MDU_LATENCY cycles after
   // the start edge for exactly one cycle, reset clears everything.
   bit           m_busy, m_write;
   int           m_age;
   logic [63:0]  m_pend;
   logic [W-1:0] m_hi, m_lo;

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 0; m_write = 0; m_age = 0; m_hi = '0; m_lo = '0;
      end else if (m_busy) begin
         if (m_write) begin
            m_busy = 0; m_write = 0;
         end else begin
            m_age++;
            if (m_age == MDU_LATENCY) begin
               m_write = 1;
               {m_hi, m_lo} = m_pend;
            end
         end
      end else if (start) begin
         m_busy = 1;
         m_age  = 1;
         m_pend = model_result(op, a, b);
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check("busy", busy, m_busy);
         check("hilo_write", hilo_write, m_write);
         check("hi_out", hi_out, m_hi);
         check("lo_out", lo_out, m_lo);
         if (hilo_write) n_writes++;
      end
   end

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
      int lat, busy_cycles;
      bit seen;
      @(posedge clk); #1;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      // Operands change right after capture; the result must not follow.
      start = 1'b0; op = ~o; a = ~x; b = y + 32'd1;
      lat = 0; busy_cycles = 0; seen = 0;
      while (!seen && lat < 60) begin
         @(negedge clk);
         lat++;
         if (busy) busy_cycles++;
         if (hilo_write) seen = 1;
      end
      check({name, "_latency"}, lat, MDU_LATENCY);
      check({name, "_busy_cycles"}, busy_cycles, MDU_LATENCY);
      check({name, "_hi"}, hi_out, eh);
      check({name, "_lo"}, lo_out, el);
      @(negedge clk);
   endtask

   task automatic wait_write(input int limit, output bit seen);
      seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (hilo_write) seen = 1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  w0;
      bit  seen;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checking = 1'b1;
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_hi", hi_out, 32'h0);
      check("reset_lo", lo_out, 32'h0);

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
      run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
      run_op("divu_zero", 2'b11, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF);
      run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

      // Second start while busy is ignored.
      w0 = n_writes;
      @(posedge clk); #1;
      start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
      @(posedge clk); #1 start = 1'b0;
      wait_write(60, seen);
      check("ignored_start_seen", seen, 1'b1);
      check("ignored_start_hi", hi_out, 32'd2);
      check("ignored_start_lo", lo_out, 32'd14);
      repeat (40) @(negedge clk);
      check("ignored_start_writes", n_writes - w0, 1);

      // Start held through DONE: accepted only on the following IDLE cycle.
      @(posedge clk); #1;
      start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd5;
      @(posedge clk); #1 start = 1'b0;
      wait_write(60, seen);
      check("done_start_first_lo", lo_out, 32'd10);
      start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
      @(posedge clk);
      @(posedge clk); #1 start = 1'b0;
      wait_write(60, seen);
      check("done_start_second_seen", seen, 1'b1);
      check("done_start_second_lo", lo_out, 32'd30);
      @(negedge clk);

      // Reset mid-operation aborts it.
      w0 = n_writes;
      @(posedge clk); #1;
      start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
      @(posedge clk); #1 start = 1'b0;
      repeat (19) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_hi", hi_out, 32'h0);
      check("abort_lo", lo_out, 32'h0);
      // Start together with reset: reset wins.
      @(posedge clk); #1 start = 1'b1; reset = 1'b1;
      @(posedge clk); #1 start = 1'b0; reset = 1'b0;
      @(negedge clk);
      check("start_reset_busy", busy, 1'b0);
      repeat (40) @(negedge clk);
      check("abort_no_write", n_writes - w0, 0);

      run_op("multu_after_abort", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multi-cycle MIPS multiply/divide engine. It is the writer side of the HI/LO register.
- Accepts MULT/MULTU/DIV/DIVU with operands rs/rt and computes over 32 iteration cycles.
- Presents {hi, lo} with a one-cycle write strobe that drives the HI/LO register's write-enable and data inputs.
- Sits in the execute stage; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  WIDTH  rs (multiplicand / dividend)
- operand_b  input  WIDTH  rt (multiplier / divisor)
- busy  output  1  high whenever state is not IDLE
- hilo_write  output  1  one-cycle strobe to the HI/LO register write-enable
- hi_out  output  WIDTH  HI result; valid when hilo_write=1
- lo_out  output  WIDTH  LO result; valid when hilo_write=1

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: state=IDLE, busy=0, hilo_write=0, hi_out=0, lo_out=0, iteration counter=0.
- FSM states: IDLE -> RUN -> FIXUP -> DONE -> IDLE.

IDLE:
- On start=1, latch op.
- Signed ops (MULT, DIV): latch |a| and |b| as magnitudes, and record sign flags.
- Unsigned ops: latch operands unchanged.
- Clear the 2*WIDTH accumulator, load counter=WIDTH-1, go to RUN.

RUN:
- One iteration per cycle for exactly WIDTH cycles; leave when counter==0.
- Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand to the upper half; shift the {acc_hi, acc_lo} product right by 1, keeping the carry out of the add.
- Divide: restoring division. Shift {rem, quo} left by 1. If rem >= divisor, rem -= divisor and quo LSB=1.
- Counter decrements every cycle.

FIXUP (1 cycle):
- MULT: negate the 64-bit product if sign_a XOR sign_b.
- DIV: negate the quotient if sign_a XOR sign_b; the remainder takes the sign of the dividend.
- Divide by zero (all ops): lo=all-ones, hi=dividend as supplied (original signed value). This is a team decision; MIPS leaves the result undefined.
- DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude path and must not trap.

DONE (1 cycle):
- hilo_write=1.
- Multiply: hi_out=product[63:32], lo_out=product[31:0].
- Divide: hi_out=remainder, lo_out=quotient.

Latency and handshake:
- start sampled at edge N.
- busy=1 from N+1 through the DONE cycle.
- hilo_write high exactly at cycle N+WIDTH+2 (34 for WIDTH=32), then IDLE.
- start while busy is ignored; no queueing.
- hi_out/lo_out hold their last values after DONE; only hilo_write drops.

Boundary conditions:
- Operands are captured at start; later operand changes have no effect.
- Reset mid-operation aborts the operation: no hilo_write, all outputs return to reset values the next cycle.
- start and reset asserted together: reset wins.
- start asserted in the DONE cycle is ignored; it is accepted only the following cycle, in IDLE.

Decomposition:
- Shared package mdu_pkg holds:
  - enum op_e {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}
  - state enum {IDLE, RUN, FIXUP, DONE}
  - constant MDU_LATENCY=WIDTH+2
- Natural sub-module: mdu_datapath (shift/add/subtract step plus sign fixup, combinational per iteration). The parent owns the FSM, counter and registers.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hilo_write at start+34, hi=0xFFFFFFFE, lo=0x00000001; busy high for 34 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100 b=7 -> lo=14, hi=2.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- Second start pulsed at cycle 10 of a busy op with different operands -> ignored; single hilo_write carries the first op's result only.
- Reset asserted at cycle 20 of MULTU 5x6 -> busy=0, hi/lo=0 next cycle, no hilo_write ever. New MULTU 5x6 afterwards -> hi=0, lo=30.
